rxuart_cfg: RTL and testbench
=============================

Name: rxuart_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver.
- Configurable data width, parity mode and stop-bit count.
- Adds false-start rejection, parity checking, framing-error and break detection, and a post-error line-recovery state.
- Sits between the board RX pin and the command/LED-array decoder; one o_stb pulse per completed frame, with per-frame status flags.

Parameters:
CLKS_PER_BAUD, 217, clocks per bit period; legal values 4..65535; counter width is derived from it.
DATA_BITS, 8, data bits per frame, 5..8, sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_uart_rx  in  1  asynchronous serial line, idles high
o_stb  out  1  one-cycle pulse: frame complete; data and flags valid this cycle
o_data  out  DATA_BITS  received word, right-aligned, LSB = first bit on the wire
o_parity_err  out  1  parity mismatch on this frame; always 0 when PARITY=0
o_frame_err  out  1  a stop bit was sampled low
o_break  out  1  break: start, all data, parity (if any) and first stop all sampled low
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser stages set to 1, state = IDLE, counter = 0.
  - o_stb, o_data, o_parity_err, o_frame_err, o_break, o_busy all 0.
- Input path: 2-flop synchroniser; all logic uses the synchronised line only.
- Baud counter:
  - baud_stb = (counter == 0); counter decrements otherwise.
  - Reload CLKS_PER_BAUD/2-1 on start detect.
  - Reload CLKS_PER_BAUD-1 on every baud_stb in START, DATA, PARITY and STOP.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: synchronised line low -> START.
  - START: on baud_stb, line high -> IDLE (glitch rejected, no o_stb); line low -> DATA with bit index 0.
  - DATA: on baud_stb, shift the sample in; after DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: on baud_stb, sample the bit; parity error when XOR(data, parity bit) != (PARITY==1 ? 1 : 0); -> STOP.
  - STOP: on baud_stb, sample; with STOP_BITS=2, the second sample occurs one baud later. Either stop sample low sets the frame error.
  - Completion: after the last stop sample, o_stb is registered high for exactly one cycle together with o_data and the flags. Next state is IDLE if the final sample was high, else WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is high, then -> IDLE. No start detection in this state.
- Break: o_break=1 implies o_frame_err=1, and o_data = 0.
- Flags and o_data hold their values until the next o_stb. They are meaningful only while o_stb is high.
- Latency (line falls at the pin at cycle 0, N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS):
  - Start sample at cycle 2 + CLKS_PER_BAUD/2.
  - Last stop sample at cycle 2 + CLKS_PER_BAUD/2 + (N-1)·CLKS_PER_BAUD.
  - o_stb one cycle after the last stop sample.
- Back-to-back frames: a new start edge must be accepted in the cycle after STOP returns to IDLE, with no idle gap required.
- Reset mid-frame: abort immediately. No o_stb is generated for the partial frame.
- Formal properties:
  - State is always one of the six defined states.
  - In IDLE, counter == 0.
  - Counter < CLKS_PER_BAUD in all states except START.
  - o_stb never high on two consecutive cycles.

Test Plan:
- Default build, CLKS_PER_BAUD=16, 8N1, send 0xA5 -> o_stb at cycle 155 after the pin falling edge; o_data=0xA5; all flags 0.
- PARITY=2 (even), STOP_BITS=2, DATA_BITS=7:
  - Send 0x41 with parity bit 0 -> o_data=0x41, o_parity_err=0.
  - Repeat with parity bit 1 -> o_parity_err=1, o_stb still pulses.
- 8N1, send 0x3C with the stop bit forced low, then the line held low 40 cycles -> o_frame_err=1, o_break=0. o_busy stays high through WAIT_HIGH and falls on the cycle after the synchronised line returns high.
- 8N1, line held low for 12 bit periods -> exactly one o_stb with o_break=1, o_frame_err=1, o_data=0x00; no further o_stb until a fresh start edge after the line returns high.
- Low glitch of 3 cycles on an idle line -> START rejects it at the mid-bit sample, returns to IDLE, no o_stb. A following valid frame 0x5A is received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three o_stb pulses with the correct data in order. Asserting i_rst_n low mid-frame during a 4th byte -> all outputs 0 asynchronously, no o_stb for that byte.

Source files
------------

// File: rtl/rxuart_cfg_if.sv
// Serial receiver bundle: the RX line in, plus the received word, strobe and status flags out.
interface rxuart_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_uart_rx;
  logic                 o_stb;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output i_uart_rx,
    input  o_stb, o_data, o_parity_err, o_frame_err, o_break, o_busy
  );

  modport slave (
    input  i_uart_rx,
    output o_stb, o_data, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface

// File: rtl/rxuart_cfg.sv
// Configurable UART receiver with configurable data width, parity and stop bits.
// Rejects false starts and detects parity, framing and break conditions.
module rxuart_cfg #(
  parameter int unsigned CLKS_PER_BAUD = 217,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rxuart_cfg_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BAUD);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BAUD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic PAR_ODD  = (PARITY == 1);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 low_q, low_d, stop2_q, stop2_d;
  logic                 stb_q, stb_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, busy_q, busy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 baud_stb;
  logic                 ferr_next;

  assign baud_stb  = (cnt_q == '0);
  assign ferr_next = ferr_q | ~sync2_q;

  // State, counter and output registers; synchroniser idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      low_q   <= 1'b0;
      stop2_q <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= bus.i_uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      low_q   <= low_d;
      stop2_q <= stop2_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; low_q tracks "every sample so far was low" for break detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = baud_stb ? '0 : cnt_q - CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    low_d   = low_q;
    stop2_d = stop2_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (baud_stb) begin
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_RELOAD;
            idx_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            low_d   = 1'b1;
            stop2_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (baud_stb) begin
          cnt_d   = FULL_RELOAD;
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          low_d   = low_q & ~sync2_q;
          if (idx_q == LAST_IDX) state_d = HAS_PAR ? S_PARITY : S_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_stb) begin
          cnt_d   = FULL_RELOAD;
          perr_d  = ((^shreg_q) ^ sync2_q) != PAR_ODD;
          low_d   = low_q & ~sync2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_stb) begin
          if (TWO_STOP && !stop2_q) begin
            cnt_d   = FULL_RELOAD;
            stop2_d = 1'b1;
            ferr_d  = ferr_next;
            low_d   = low_q & ~sync2_q;
          end else begin
            stb_d   = 1'b1;
            data_d  = shreg_q;
            pe_d    = perr_q;
            fe_d    = ferr_next;
            brk_d   = stop2_q ? low_q : (low_q & ~sync2_q);
            state_d = sync2_q ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.o_stb        = stb_q;
  assign bus.o_data       = data_q;
  assign bus.o_parity_err = pe_q;
  assign bus.o_frame_err  = fe_q;
  assign bus.o_break      = brk_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_rxuart_cfg.sv
// Bench for rxuart_cfg: an 8N1 instance (a) and a 7E2 instance (b), both at 16 clocks per bit.
module tb_rxuart_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rxuart_cfg_if #(.DATA_BITS(8)) if_a ();
  rxuart_cfg_if #(.DATA_BITS(7)) if_b ();

  rxuart_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
  rxuart_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b));

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         last_cyc[2];
  logic [7:0] last_data[2];
  logic       last_pe[2], last_fe[2], last_brk[2];
  int         stb_count[2];
  logic       stb_prev[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame configuration of each instance.
  function automatic int nd_of(input int d); return (d == 0) ? 8 : 7; endfunction
  function automatic int pm_of(input int d); return (d == 0) ? 0 : 2; endfunction
  function automatic int ns_of(input int d); return (d == 0) ? 1 : 2; endfunction

  // Wire image of a frame, bit 0 first on the line; unused upper bits idle high.
  function automatic logic [31:0] frame(input int d, input logic [7:0] dat,
                                        input logic flip_par, input logic stop_low);
    logic [31:0] f;
    logic [7:0]  m;
    int          pos;
    logic        p;
    f = '1;
    m = (nd_of(d) == 8) ? dat : (dat & 8'h7F);
    f[0] = 1'b0;
    for (int i = 0; i < nd_of(d); i++) f[1+i] = m[i];
    pos = 1 + nd_of(d);
    if (pm_of(d) != 0) begin
      p = (pm_of(d) == 1) ? ~(^m) : (^m);
      f[pos] = p ^ flip_par;
      pos++;
    end
    for (int k = 0; k < ns_of(d); k++) f[pos+k] = ~stop_low;
    return f;
  endfunction

  task automatic set_rx(input int d, input logic v);
    if (d == 0) if_a.i_uart_rx = v;
    else        if_b.i_uart_rx = v;
  endtask

  // Drive nbits wire bits; the model predicts the frame's strobe cycle, data and flags.
  task automatic tx(input int d, input logic [31:0] bits, input int nbits);
    exp_t       e;
    logic [7:0] dat;
    logic       pbit;
    int         nd, pm, ns, n, t0;
    nd = nd_of(d); pm = pm_of(d); ns = ns_of(d);
    n  = 1 + nd + ((pm != 0) ? 1 : 0) + ns;
    t0 = cyc;
    dat = 8'h00;
    for (int i = 0; i < nd; i++) dat[i] = bits[1+i];
    pbit = bits[1+nd];
    e.cyc  = t0 + 3 + CPB / 2 + (n - 1) * CPB;
    e.data = dat;
    e.pe   = (pm != 0) && (((^dat) ^ pbit) != (pm == 1));
    e.fe   = 1'b0;
    for (int k = 0; k < ns; k++) if (!bits[n-ns+k]) e.fe = 1'b1;
    e.brk  = 1'b1;
    for (int i = 0; i <= n - ns; i++) if (bits[i]) e.brk = 1'b0;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      set_rx(d, bits[i]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic cmp_dut(input int d, input logic stb, input logic [7:0] data,
                         input logic pe, input logic fe, input logic brk);
    exp_t e;
    logic have;
    have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (have) e = (d == 0) ? q_a[0] : q_b[0];
    if (stb) begin
      stb_count[d]++;
      last_cyc[d] = cyc; last_data[d] = data;
      last_pe[d] = pe; last_fe[d] = fe; last_brk[d] = brk;
      check($sformatf("stb_single_cycle_%0d", d), 32'(stb_prev[d]), 32'd0);
      if (!have) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_stb dut%0d: got stb at cycle %0d expected none", d, cyc);
      end else begin
        check($sformatf("stb_cycle_%0d", d), 32'(cyc), 32'(e.cyc));
        check($sformatf("data_%0d", d), 32'(data), 32'(e.data));
        check($sformatf("parity_err_%0d", d), 32'(pe), 32'(e.pe));
        check($sformatf("frame_err_%0d", d), 32'(fe), 32'(e.fe));
        check($sformatf("break_%0d", d), 32'(brk), 32'(e.brk));
        if (d == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
      end
    end else if (have && e.cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL missing_stb dut%0d: got none expected stb at cycle %0d", d, e.cyc);
      if (d == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
    end
    stb_prev[d] = stb;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stb_prev[0] = 1'b0;
      stb_prev[1] = 1'b0;
    end else begin
      cmp_dut(0, if_a.o_stb, if_a.o_data, if_a.o_parity_err, if_a.o_frame_err, if_a.o_break);
      cmp_dut(1, if_b.o_stb, {1'b0, if_b.o_data}, if_b.o_parity_err, if_b.o_frame_err, if_b.o_break);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_a_outs"}, {27'd0, if_a.o_stb, if_a.o_parity_err, if_a.o_frame_err,
                             if_a.o_break, if_a.o_busy}, 32'd0);
    check({tag, "_a_data"}, 32'(if_a.o_data), 32'd0);
    check({tag, "_b_outs"}, {27'd0, if_b.o_stb, if_b.o_parity_err, if_b.o_frame_err,
                             if_b.o_break, if_b.o_busy}, 32'd0);
    check({tag, "_b_data"}, 32'(if_b.o_data), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, th, c0;
    stb_count[0] = 0; stb_count[1] = 0;
    stb_prev[0] = 1'b0; stb_prev[1] = 1'b0;
    if_a.i_uart_rx = 1'b1;
    if_b.i_uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5: strobe 155 cycles after the pin edge.
    check("frame_image_a5", frame(0, 8'hA5, 1'b0, 1'b0), 32'hFFFF_FF4A);
    t0 = cyc;
    tx(0, frame(0, 8'hA5, 1'b0, 1'b0), 10);
    repeat (4) @(negedge clk);
    check("a5_latency", 32'(last_cyc[0] - t0), 32'd155);
    check("a5_data", 32'(last_data[0]), 32'hA5);
    check("a5_flags", {29'd0, last_pe[0], last_fe[0], last_brk[0]}, 32'd0);

    // 7E2 0x41 with correct and flipped parity bit.
    t0 = cyc;
    tx(1, frame(1, 8'h41, 1'b0, 1'b0), 11);
    repeat (4) @(negedge clk);
    check("b41_latency", 32'(last_cyc[1] - t0), 32'd171);
    check("b41_data", 32'(last_data[1]), 32'h41);
    check("b41_parity_ok", 32'(last_pe[1]), 32'd0);
    tx(1, frame(1, 8'h41, 1'b1, 1'b0), 11);
    repeat (4) @(negedge clk);
    check("b41_parity_bad", 32'(last_pe[1]), 32'd1);
    check("b41_count", 32'(stb_count[1]), 32'd2);

    // Low stop bit then line held low: frame error, busy until the line recovers.
    tx(0, frame(0, 8'h3C, 1'b0, 1'b1), 10);
    repeat (40) @(negedge clk);
    check("fe_data", 32'(last_data[0]), 32'h3C);
    check("fe_flag", {30'd0, last_fe[0], last_brk[0]}, 32'b10);
    set_rx(0, 1'b1);
    th = cyc;
    repeat (2) @(negedge clk);
    check("fe_busy_held", {31'd0, if_a.o_busy}, 32'd1);
    @(negedge clk);
    check("fe_busy_drop_cycle", 32'(cyc - th), 32'd3);
    check("fe_busy_dropped", {31'd0, if_a.o_busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Break: 12 bit periods low.
    c0 = stb_count[0];
    tx(0, 32'h0, 12);
    set_rx(0, 1'b1);
    repeat (60) @(negedge clk);
    check("brk_single", 32'(stb_count[0] - c0), 32'd1);
    check("brk_flags", {30'd0, last_brk[0], last_fe[0]}, 32'b11);
    check("brk_data", 32'(last_data[0]), 32'h00);

    // 3-cycle glitch is rejected, then a valid frame.
    c0 = stb_count[0];
    set_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch_no_stb", 32'(stb_count[0] - c0), 32'd0);
    check("glitch_idle", {31'd0, if_a.o_busy}, 32'd0);
    tx(0, frame(0, 8'h5A, 1'b0, 1'b0), 10);
    repeat (4) @(negedge clk);
    check("after_glitch_data", 32'(last_data[0]), 32'h5A);

    // Back-to-back frames, then reset in the middle of a fourth.
    c0 = stb_count[0];
    tx(0, frame(0, 8'h00, 1'b0, 1'b0), 10);
    tx(0, frame(0, 8'hFF, 1'b0, 1'b0), 10);
    tx(0, frame(0, 8'h81, 1'b0, 1'b0), 10);
    check("b2b_count", 32'(stb_count[0] - c0), 32'd3);
    check("b2b_last", 32'(last_data[0]), 32'h81);
    c0 = stb_count[0];
    set_rx(0, 1'b0);
    repeat (40) @(negedge clk);
    check("mid_frame_busy", {31'd0, if_a.o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    set_rx(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("reset_no_stb", 32'(stb_count[0] - c0), 32'd0);
    check("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
